// File: rtl/i2s_rx_frame.sv
// I2S receiver: aligns to WS edges and deserialises left/right slots into PCM word pairs.
// Optional handshake: define I2S_RX_READY_EN to add out_ready and overrun detection.
module i2s_rx_frame #(
  parameter int unsigned SAMPLE_BITS = 8,
  parameter int unsigned DATA_DELAY  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ws,
  input  logic                   data_in,
`ifdef I2S_RX_READY_EN
  input  logic                   out_ready,
`endif
  output logic [SAMPLE_BITS-1:0] left_data,
  output logic [SAMPLE_BITS-1:0] right_data,
  output logic                   out_valid,
  output logic                   short_err,
  output logic                   overrun_err
);

  localparam int unsigned CW = $clog2(SAMPLE_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   prev_ws_q;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   chan_q, chan_d;
  logic [SAMPLE_BITS-1:0] left_hold_q, left_hold_d;
  logic                   left_pending_q, left_pending_d;
  logic [SAMPLE_BITS-1:0] left_data_q, left_data_d;
  logic [SAMPLE_BITS-1:0] right_data_q, right_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   short_err_q, short_err_d;
  logic                   overrun_err_q, overrun_err_d;

  logic                   ws_edge_c;
  logic                   word_done_c;
  logic [SAMPLE_BITS-1:0] word_c;

  assign ws_edge_c = (ws != prev_ws_q);
  assign word_c    = {shift_q[SAMPLE_BITS-2:0], data_in};

  // Next-state, capture and pair-assembly logic
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    chan_d         = chan_q;
    left_hold_d    = left_hold_q;
    left_pending_d = left_pending_q;
    left_data_d    = left_data_q;
    right_data_d   = right_data_q;
    short_err_d    = 1'b0;
    overrun_err_d  = 1'b0;
    word_done_c    = 1'b0;
`ifdef I2S_RX_READY_EN
    out_valid_d    = out_valid_q && !out_ready;
`else
    out_valid_d    = 1'b0;
`endif

    case (state_q)
      ST_CAPTURE: begin
        if (cnt_q == CW'(SAMPLE_BITS - 1)) begin
          word_done_c = 1'b1;
          state_d     = ST_DONE;
        end else if (ws_edge_c) begin
          short_err_d = 1'b1;
          if (!chan_q) begin
            left_pending_d = 1'b0;
          end
        end else begin
          shift_d = word_c;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
      end
    endcase

    if (word_done_c) begin
      if (!chan_q) begin
        left_hold_d    = word_c;
        left_pending_d = 1'b1;
      end else if (left_pending_q) begin
        left_data_d    = left_hold_q;
        right_data_d   = word_c;
        out_valid_d    = 1'b1;
        left_pending_d = 1'b0;
`ifdef I2S_RX_READY_EN
        overrun_err_d  = out_valid_q && !out_ready;
`endif
      end
    end

    // Any WS edge starts a new slot; with a one-bit delay the edge cycle is the skipped bit
    if (ws_edge_c) begin
      chan_d  = ws;
      state_d = ST_CAPTURE;
      if (DATA_DELAY == 0) begin
        shift_d = word_c;
        cnt_d   = CW'(1);
      end else begin
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    prev_ws_q <= ws;
    if (reset) begin
      state_q        <= ST_IDLE;
      shift_q        <= '0;
      cnt_q          <= '0;
      chan_q         <= 1'b0;
      left_hold_q    <= '0;
      left_pending_q <= 1'b0;
      left_data_q    <= '0;
      right_data_q   <= '0;
      out_valid_q    <= 1'b0;
      short_err_q    <= 1'b0;
      overrun_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      chan_q         <= chan_d;
      left_hold_q    <= left_hold_d;
      left_pending_q <= left_pending_d;
      left_data_q    <= left_data_d;
      right_data_q   <= right_data_d;
      out_valid_q    <= out_valid_d;
      short_err_q    <= short_err_d;
      overrun_err_q  <= overrun_err_d;
    end
  end

  assign left_data   = left_data_q;
  assign right_data  = right_data_q;
  assign out_valid   = out_valid_q;
  assign short_err   = short_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: doc/i2s_rx_frame.md
# i2s_rx_frame

Parametrised I2S receiver that deserialises a stereo serial stream into coherent left/right PCM word pairs. It sits directly behind the ui_in serial pin and next to the word-select generator in tt04_design, and replaces the fixed 8-bit, free-running shift capture with the following:
- slot alignment to WS edges;
- a selectable data delay;
- short-slot error detection;
- a pair-valid output with an optional ready handshake.

## Interface
- SAMPLE_BITS, 8, PCM word width; legal range 4..32.
- DATA_DELAY, 1, bit clocks from a WS edge to the MSB. 1 = Philips I2S, 0 = left-justified. Legal values are 0 and 1 only.
- clk  input  1  bit clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- ws  input  1  word select; 0 = left slot, 1 = right slot.
- data_in  input  1  serial data, MSB first, sampled on posedge clk.
- out_ready  input  1  consumer ready; present only when I2S_RX_READY_EN is defined.
- left_data  output  SAMPLE_BITS  left word of the last emitted pair.
- right_data  output  SAMPLE_BITS  right word of the last emitted pair.
- out_valid  output  1  a pair is presented.
- short_err  output  1  one-cycle pulse when a slot ends before SAMPLE_BITS bits are captured.
- overrun_err  output  1  one-cycle pulse when an unaccepted pair is overwritten.

## Operation
- Registers:
  - prev_ws;
  - shift register (SAMPLE_BITS);
  - bit counter, width $clog2(SAMPLE_BITS+1);
  - slot channel;
  - left hold register;
  - left_pending flag;
  - the outputs.
- State machine:
  - IDLE: after reset. No capture. A WS edge (ws != prev_ws) moves to DELAY if DATA_DELAY=1, or straight to CAPTURE if DATA_DELAY=0.
  - DELAY: one cycle. The bit sampled here is ignored. Next state is CAPTURE.
  - CAPTURE: shift data_in in MSB first and increment the counter. When the SAMPLE_BITS-th bit is sampled, the word completes and the state goes to DONE.
  - DONE: ignore data until the next WS edge, which goes to DELAY or CAPTURE.
- Slot channel is latched from ws on the cycle the edge is detected.
- With DATA_DELAY=0, the bit sampled on the edge cycle is the MSB.
- Left word completion: store the word in the left hold register and set left_pending.
- Right word completion:
  - If left_pending: load left_data from the hold register and right_data from the completed word, assert out_valid, clear left_pending.
  - If not left_pending: discard the right word silently, with no error.
- WS edge in DELAY or CAPTURE:
  - Discard the partial word and pulse short_err.
  - For a discarded left word, clear left_pending.
  - Restart slot alignment for the new channel.
- prev_ws updates every cycle, including during reset (prev_ws <= ws), so reset release never produces a spurious edge.
- Reset values: state IDLE; left_data, right_data, out_valid, short_err, overrun_err, left_pending and counter all 0.
- Reset mid-word: the partial word is lost and no error is flagged.

## Timing
- Slot start cycle s = edge cycle + DATA_DELAY. Bits are sampled at s .. s+SAMPLE_BITS-1.
- Latency: outputs update at the posedge that samples the right LSB and are visible in the following cycle.
- A WS edge coinciding with the final (SAMPLE_BITS-th) sample cycle:
  - the word completes normally, with no short_err;
  - the new slot begins from that edge.
- Slots longer than SAMPLE_BITS: trailing bits are ignored.
- Slots of exactly SAMPLE_BITS + DATA_DELAY cycles must work back-to-back without loss.

## Configuration
- I2S_RX_READY_EN defined:
  - out_ready exists and out_valid holds until a posedge with out_valid && out_ready; it then drops on the next cycle.
  - If a new pair completes on the same posedge as an accept, load the new pair and keep out_valid high, with no error.
  - If a new pair completes while out_valid && !out_ready, overwrite the data, keep out_valid high and pulse overrun_err.
- I2S_RX_READY_EN undefined:
  - no out_ready port;
  - out_valid is a one-cycle pulse per pair;
  - overrun_err is tied to 0;
  - left_data and right_data hold until the next pair.

## Test plan
All scenarios use SAMPLE_BITS=8, DATA_DELAY=1 and a WS half-period of 32 clk cycles unless stated otherwise.
- Left slot 0xA5 then right slot 0x3C -> left_data=0xA5 and right_data=0x3C one cycle after the right LSB sample; out_valid pulses once.
- Reset release with ws=1, first slot right (0x11), then left 0x22 and right 0x33 -> the first right word is dropped; a single pair 0x22/0x33 is emitted; short_err stays 0.
- DATA_DELAY=0, left 0x80 with MSB on the edge cycle -> left_data=0x80; the DATA_DELAY=1 build with the same stimulus yields 0x00 or a shifted word as defined, not 0x80.
- WS toggles after 5 bits of the left slot -> short_err pulses one cycle; no pair is emitted for that frame; the next full frame (0x5A/0xC3) is emitted correctly.
- I2S_RX_READY_EN, out_ready held 0 across two frames (0x01/0x02 then 0x03/0x04) -> overrun_err pulses once; out_valid stays high; data 0x03/0x04; out_ready=1 for one cycle drops out_valid.
- Reset asserted mid right slot, released with ws constant -> all outputs 0; no out_valid until the next complete left+right pair.
